// File: rtl/dmem_store_ctrl_if.sv
// dmem_store_ctrl_if
// Bundles the store-request side (from the control unit) and the data-memory
// write side of the store sequencer into one interface.
//
// Signals:
//   store_req   - store request, level-sampled every rising edge
//   AR_out      - store address from the address register
//   MDR_out     - store data from the MDR (only the low MEM_W bits are used)
//   dmem_addr   - registered memory address
//   dmem_wdata  - registered memory write data
//   dmem_write  - registered write strobe, active high
//   busy        - sequencer is not idle
//   store_done  - one-cycle pulse when a write completes
//   pend_full   - the one-deep pending slot holds a request
//   overflow    - sticky, a request was dropped
//
// Modports:
//   master - the requesting side (control unit / testbench)
//   slave  - the store sequencer itself
interface dmem_store_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int MEM_W  = 8
);
    logic              store_req;
    logic [ADDR_W-1:0] AR_out;
    logic [DATA_W-1:0] MDR_out;
    logic [ADDR_W-1:0] dmem_addr;
    logic [MEM_W-1:0]  dmem_wdata;
    logic              dmem_write;
    logic              busy;
    logic              store_done;
    logic              pend_full;
    logic              overflow;

    modport master (
        output store_req, AR_out, MDR_out,
        input  dmem_addr, dmem_wdata, dmem_write, busy, store_done, pend_full, overflow
    );

    modport slave (
        input  store_req, AR_out, MDR_out,
        output dmem_addr, dmem_wdata, dmem_write, busy, store_done, pend_full, overflow
    );
endinterface

// File: rtl/dmem_store_ctrl.sv
// dmem_store_ctrl
// Data-memory store sequencer. A store request captures the address and the
// low byte of the MDR, then drives one byte write to the data memory with a
// setup / strobe / hold sequence. The strobe lasts WAIT_CYCLES+1 cycles
// (WAIT_CYCLES must lie in 0..15). A one-deep pending slot absorbs a request that
// arrives mid-write; a request arriving with the slot already full is
// dropped and flagged in the sticky overflow bit.
//
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - dmem_store_ctrl_if slave modport (request inputs, memory
//            outputs and status flags)
module dmem_store_ctrl #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int MEM_W       = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    dmem_store_ctrl_if.slave    bus
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WRITE,
        HOLD,
        DONE
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t            state;
    logic [3:0]        wait_cnt;
    logic [ADDR_W-1:0] pend_addr;
    logic [MEM_W-1:0]  pend_data;

    // Sequencer, pending slot and all outputs live in one registered block so
    // that every output is a flop and reset clears everything at once,
    // including dropping the strobe asynchronously in the middle of a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            wait_cnt       <= '0;
            pend_addr      <= '0;
            pend_data      <= '0;
            bus.dmem_addr  <= '0;
            bus.dmem_wdata <= '0;
            bus.dmem_write <= 1'b0;
            bus.busy       <= 1'b0;
            bus.store_done <= 1'b0;
            bus.pend_full  <= 1'b0;
            bus.overflow   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.store_req) begin
                        bus.dmem_addr  <= bus.AR_out;
                        bus.dmem_wdata <= bus.MDR_out[MEM_W-1:0];
                        bus.busy       <= 1'b1;
                        state          <= SETUP;
                    end
                end

                SETUP: begin
                    wait_cnt       <= WAIT_INIT;
                    bus.dmem_write <= 1'b1;
                    state          <= WRITE;
                end

                WRITE: begin
                    if (wait_cnt == 4'd0) begin
                        bus.dmem_write <= 1'b0;
                        state          <= HOLD;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end

                HOLD: begin
                    bus.store_done <= 1'b1;
                    state          <= DONE;
                end

                DONE: begin
                    bus.store_done <= 1'b0;
                    // The pending slot has priority over a request arriving
                    // now; that request refills the slot below instead.
                    if (bus.pend_full) begin
                        bus.dmem_addr  <= pend_addr;
                        bus.dmem_wdata <= pend_data;
                        state          <= SETUP;
                    end else if (bus.store_req) begin
                        bus.dmem_addr  <= bus.AR_out;
                        bus.dmem_wdata <= bus.MDR_out[MEM_W-1:0];
                        state          <= SETUP;
                    end else begin
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase

            // Pending slot. In DONE a full slot is emptied on this edge, so a
            // simultaneous request can take its place without being lost.
            if (state == SETUP || state == WRITE || state == HOLD) begin
                if (bus.store_req) begin
                    if (!bus.pend_full) begin
                        pend_addr     <= bus.AR_out;
                        pend_data     <= bus.MDR_out[MEM_W-1:0];
                        bus.pend_full <= 1'b1;
                    end else begin
                        bus.overflow <= 1'b1;
                    end
                end
            end else if (state == DONE && bus.pend_full) begin
                if (bus.store_req) begin
                    pend_addr <= bus.AR_out;
                    pend_data <= bus.MDR_out[MEM_W-1:0];
                end else begin
                    bus.pend_full <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_store_ctrl.sv
// tb_dmem_store_ctrl
// Self-checking bench for dmem_store_ctrl. A WAIT_CYCLES=1 instance carries
// the table of single stores plus the back-to-back, overflow and reset
// sequences; a WAIT_CYCLES=0 instance checks the shortest strobe. Every
// request that should reach memory is pushed to a scoreboard queue and popped
// on the rising edge of the write strobe.
module tb_dmem_store_ctrl;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int MEM_W  = 8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    dmem_store_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_W(MEM_W)) bus1 ();
    dmem_store_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_W(MEM_W)) bus0 ();

    dmem_store_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_W(MEM_W), .WAIT_CYCLES(1)
    ) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    dmem_store_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_W(MEM_W), .WAIT_CYCLES(0)
    ) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    typedef struct {
        logic [15:0] ar;
        logic [15:0] mdr;
        logic [15:0] exp_addr;
        logic [7:0]  exp_wdata;
    } vec_t;

    wr_t  sb_q[$];
    wr_t  mon_e;
    vec_t vecs[5];

    int vec_count  = 0;
    int miss_count = 0;
    int exp_done   = 0;
    int done_seen  = 0;
    logic prev_write = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miss_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drives the request inputs for the next rising edge; a request that is
    // expected to reach memory is also queued for the scoreboard.
    task automatic applyStimulus(input logic req, input logic [15:0] ar,
                                 input logic [15:0] mdr, input logic expect_write);
        bus1.store_req = req;
        bus1.AR_out    = ar;
        bus1.MDR_out   = mdr;
        if (req && expect_write) begin
            sb_q.push_back('{addr: ar, data: mdr[7:0]});
            exp_done++;
        end
    endtask

    task automatic checkAllReset(input string tag);
        checkOutput({tag, "_addr"},  32'(bus1.dmem_addr),  32'h0);
        checkOutput({tag, "_wdata"}, 32'(bus1.dmem_wdata), 32'h0);
        checkOutput({tag, "_write"}, 32'(bus1.dmem_write), 32'h0);
        checkOutput({tag, "_busy"},  32'(bus1.busy),       32'h0);
        checkOutput({tag, "_done"},  32'(bus1.store_done), 32'h0);
        checkOutput({tag, "_pend"},  32'(bus1.pend_full),  32'h0);
        checkOutput({tag, "_ovf"},   32'(bus1.overflow),   32'h0);
    endtask

    // One isolated store on the W=1 instance, checked cycle by cycle against
    // the expected profile: strobe in cycles 2-3, done in 5, idle in 6.
    task automatic runSingle(input logic [15:0] ar, input logic [15:0] mdr,
                             input logic [15:0] exp_addr, input logic [7:0] exp_wdata);
        @(negedge clk);
        applyStimulus(1'b1, ar, mdr, 1'b1);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) applyStimulus(1'b0, ~ar, ~mdr, 1'b0);
            checkOutput("single_write", 32'(bus1.dmem_write), 32'(c == 2 || c == 3));
            checkOutput("single_done",  32'(bus1.store_done), 32'(c == 5));
            checkOutput("single_busy",  32'(bus1.busy),       32'(c <= 5));
            if (c <= 5) begin
                checkOutput("single_addr",  32'(bus1.dmem_addr),  32'(exp_addr));
                checkOutput("single_wdata", 32'(bus1.dmem_wdata), 32'(exp_wdata));
            end
        end
    endtask

    // Scoreboard monitor: each new strobe must match the oldest queued store.
    always @(negedge clk) begin
        if (bus1.dmem_write && !prev_write) begin
            if (sb_q.size() == 0) begin
                vec_count++;
                miss_count++;
                $display("[TB] FAIL strobe_unexpected: got strobe at addr %0h, expected no write",
                         bus1.dmem_addr);
            end else begin
                mon_e = sb_q.pop_front();
                checkOutput("strobe_addr",  32'(bus1.dmem_addr),  32'(mon_e.addr));
                checkOutput("strobe_data",  32'(bus1.dmem_wdata), 32'(mon_e.data));
            end
        end
        if (bus1.store_done) done_seen++;
        prev_write <= bus1.dmem_write;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
        bus0.store_req = 1'b0;
        bus0.AR_out    = 16'h0;
        bus0.MDR_out   = 16'h0;

        vecs[0] = '{16'h01A4, 16'hBEEF, 16'h01A4, 8'hEF};
        vecs[1] = '{16'h0000, 16'hFF00, 16'h0000, 8'h00};
        vecs[2] = '{16'hFFFF, 16'h1234, 16'hFFFF, 8'h34};
        vecs[3] = '{16'h8001, 16'h00FF, 16'h8001, 8'hFF};
        vecs[4] = '{16'h5A5A, 16'hA5C3, 16'h5A5A, 8'hC3};

        repeat (2) @(negedge clk);
        checkAllReset("reset");
        rst_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            runSingle(vecs[v].ar, vecs[v].mdr, vecs[v].exp_addr, vecs[v].exp_wdata);
        end

        // Zero wait cycles: one-cycle strobe, done four cycles after request.
        @(negedge clk);
        bus0.store_req = 1'b1;
        bus0.AR_out    = 16'h0BCD;
        bus0.MDR_out   = 16'h7766;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) bus0.store_req = 1'b0;
            checkOutput("w0_write", 32'(bus0.dmem_write), 32'(c == 2));
            checkOutput("w0_done",  32'(bus0.store_done), 32'(c == 4));
            checkOutput("w0_busy",  32'(bus0.busy),       32'(c <= 4));
            if (c == 1) begin
                checkOutput("w0_addr",  32'(bus0.dmem_addr),  32'h0BCD);
                checkOutput("w0_wdata", 32'(bus0.dmem_wdata), 32'h66);
            end
        end

        // B arrives during A's strobe and waits in the pending slot.
        @(negedge clk);
        applyStimulus(1'b1, 16'h0010, 16'h0011, 1'b1);
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (c == 1) applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
            if (c == 2) applyStimulus(1'b1, 16'h0020, 16'hAB22, 1'b1);
            if (c == 3) applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
            checkOutput("b2b_pend",  32'(bus1.pend_full),  32'(c >= 3 && c <= 5));
            checkOutput("b2b_done",  32'(bus1.store_done), 32'(c == 5 || c == 10));
            checkOutput("b2b_write", 32'(bus1.dmem_write), 32'(c == 2 || c == 3 || c == 7 || c == 8));
            checkOutput("b2b_busy",  32'(bus1.busy),       32'(c <= 10));
            checkOutput("b2b_ovf",   32'(bus1.overflow),   32'h0);
            if (c == 5) checkOutput("b2b_addr_a", 32'(bus1.dmem_addr), 32'h0010);
            if (c == 6) begin
                checkOutput("b2b_addr_b",  32'(bus1.dmem_addr),  32'h0020);
                checkOutput("b2b_wdata_b", 32'(bus1.dmem_wdata), 32'h22);
            end
        end

        // Request sampled in DONE with an empty slot goes straight to SETUP.
        @(negedge clk);
        applyStimulus(1'b1, 16'h1111, 16'h0044, 1'b1);
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (c == 1) applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
            if (c == 5) applyStimulus(1'b1, 16'h2222, 16'h0055, 1'b1);
            if (c == 6) applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
            checkOutput("done_req_busy", 32'(bus1.busy),       32'(c <= 10));
            checkOutput("done_req_done", 32'(bus1.store_done), 32'(c == 5 || c == 10));
            checkOutput("done_req_pend", 32'(bus1.pend_full),  32'h0);
            if (c == 6) begin
                checkOutput("done_req_addr",  32'(bus1.dmem_addr),  32'h2222);
                checkOutput("done_req_wdata", 32'(bus1.dmem_wdata), 32'h55);
            end
        end

        // A, B, C on consecutive cycles: C is dropped and overflow sticks.
        @(negedge clk);
        applyStimulus(1'b1, 16'h0A0A, 16'h00AA, 1'b1);
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            if (c == 1) applyStimulus(1'b1, 16'h0B0B, 16'h00BB, 1'b1);
            if (c == 2) applyStimulus(1'b1, 16'h0C0C, 16'h00CC, 1'b0);
            if (c == 3) applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
            checkOutput("ovf_flag",  32'(bus1.overflow),   32'(c >= 3));
            checkOutput("ovf_pend",  32'(bus1.pend_full),  32'(c >= 2 && c <= 5));
            checkOutput("ovf_done",  32'(bus1.store_done), 32'(c == 5 || c == 10));
            checkOutput("ovf_busy",  32'(bus1.busy),       32'(c <= 10));
            checkOutput("ovf_write", 32'(bus1.dmem_write), 32'(c == 2 || c == 3 || c == 7 || c == 8));
        end

        // Reset during a strobe with the slot full: everything clears at once.
        @(negedge clk);
        applyStimulus(1'b1, 16'h0D0D, 16'h00DD, 1'b1);
        @(negedge clk);
        applyStimulus(1'b1, 16'h0F0F, 16'h00FF, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
        checkOutput("rst_mid_write_pre", 32'(bus1.dmem_write), 32'h1);
        checkOutput("rst_mid_pend_pre",  32'(bus1.pend_full),  32'h1);
        // The first store strobes but is cut short, so it never signals done.
        exp_done--;
        #2;
        rst_n = 1'b0;
        #1;
        checkAllReset("rst_mid");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            checkOutput("rst_after_done",  32'(bus1.store_done), 32'h0);
            checkOutput("rst_after_busy",  32'(bus1.busy),       32'h0);
            checkOutput("rst_after_write", 32'(bus1.dmem_write), 32'h0);
        end
        runSingle(16'h0E0E, 16'h12EE, 16'h0E0E, 8'hEE);

        @(negedge clk);
        checkOutput("sb_empty",   32'(sb_q.size()), 32'h0);
        checkOutput("done_count", 32'(done_seen),   32'(exp_done));

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule

// File: doc/dmem_store_ctrl.md
# dmem_store_ctrl

Data-memory store sequencer; the write-side counterpart of the MDR load path. On a store request from the control unit it captures the address register (AR) and the MDR value, then drives a single byte write to the 8-bit data memory using a fixed setup / write-strobe / hold sequence. A one-deep pending slot absorbs a store request that arrives while a write is in progress. It asserts `store_done` for one cycle when each write completes.

## Interface
Parameters:
- `ADDR_W`, default 16: width of the AR input and of `dmem_addr`.
- `DATA_W`, default 16: width of the MDR input.
- `MEM_W`, default 8: data memory width. Only `MDR_out[MEM_W-1:0]` is written.
- `WAIT_CYCLES`, default 1: extra cycles `dmem_write` stays high. Legal range 0..15; the strobe lasts `WAIT_CYCLES+1` cycles.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `store_req`, input, 1: store request from the control unit, sampled on every rising edge.
- `AR_out`, input, ADDR_W: store address.
- `MDR_out`, input, DATA_W: store data.
- `dmem_addr`, output, ADDR_W: memory address, registered.
- `dmem_wdata`, output, MEM_W: memory write data, registered.
- `dmem_write`, output, 1: memory write strobe, registered, active high.
- `busy`, output, 1: high whenever state ≠ IDLE.
- `store_done`, output, 1: one-cycle pulse in the DONE state.
- `pend_full`, output, 1: the pending slot holds a request.
- `overflow`, output, 1: sticky flag, set when a request is dropped; cleared only by reset.

## Operation
States: IDLE, SETUP, WRITE, HOLD, DONE. Encoding is implementation choice.

Transitions:
- IDLE with `store_req`: latch `AR_out` into `dmem_addr` and `MDR_out[MEM_W-1:0]` into `dmem_wdata`, then go to SETUP.
- SETUP: `dmem_write` = 0 with address and data stable. Go to WRITE and load the wait counter with `WAIT_CYCLES`.
- WRITE: `dmem_write` = 1. If the counter is 0, go to HOLD; otherwise decrement it.
- HOLD: `dmem_write` = 0, address and data unchanged. Go to DONE.
- DONE: `store_done` = 1.
  - If `pend_full`, load the address and data from the pending slot, clear the slot, and go to SETUP.
  - Otherwise, if `store_req`, latch directly from the inputs and go to SETUP.
  - Otherwise go to IDLE.

Pending slot:
- `store_req` sampled in SETUP, WRITE or HOLD, with the slot empty: capture AR and MDR low byte into the slot and set `pend_full`.
- `store_req` sampled in DONE while `pend_full`: the slot is consumed and refilled with the new request at the same edge; nothing is dropped.
- `store_req` sampled while the slot is full and not being consumed: the request is dropped and `overflow` is set.

Data rules:
- `MDR_out[DATA_W-1:MEM_W]` is ignored. There is no sign or zero handling.
- Address and data change only on the edge that enters SETUP. They stay constant from SETUP through DONE.

## Timing
- Reset values (asynchronous on `rst_n` low): state IDLE; `dmem_addr` = 0, `dmem_wdata` = 0, `dmem_write` = 0, `busy` = 0, `store_done` = 0, `pend_full` = 0, `overflow` = 0; wait counter 0.
- Reset asserted mid-write: `dmem_write` drops immediately (asynchronously) and the pending request is discarded. No `store_done` is produced.
- Latency: with `store_req` sampled at edge E0, SETUP runs in cycle 1, WRITE in cycles 2..2+W (W = `WAIT_CYCLES`), HOLD in cycle 3+W and DONE in cycle 4+W.
  - Default W=1: `dmem_write` is high in cycles 2–3 and `store_done` in cycle 5.
- Back-to-back: a pending or in-DONE request enters SETUP in the cycle after DONE. Throughput is one store per W+4 cycles; there is no IDLE bubble.
- `store_req` is level-sampled. A request held high for N cycles is treated as N requests, subject to the pending and overflow rules.

## Test plan
1. Reset, then AR=0x01A4, MDR=0xBEEF, `store_req` for 1 cycle, W=1 → `dmem_addr`=0x01A4 and `dmem_wdata`=0xEF from cycle 1; `dmem_write` high in cycles 2–3 only; `store_done` in cycle 5; `busy` low in cycle 6.
2. W=0 → `dmem_write` high for exactly 1 cycle; `store_done` 4 cycles after the request.
3. Request A (0x0010/0x11) followed by B (0x0020/0x22) issued in A's WRITE cycle → `pend_full` high until A's DONE; B's SETUP in the cycle after A's `store_done`; two strobes with the correct address and data; `overflow` stays 0.
4. Requests A, B, C on three consecutive cycles → A and B written; C dropped; `overflow`=1 and it persists after return to IDLE.
5. Request sampled in the DONE cycle with the slot empty → the next store's SETUP follows immediately; `busy` never drops between the two stores.
6. `rst_n` pulsed low during WRITE with the slot full → `dmem_write`=0 immediately; all outputs at reset values; no `store_done`; a fresh request afterwards completes normally.
